// File: rtl/aes_encrypt_round_ctrl.sv
// Round sequencer for an iterative AES encrypt datapath: initial AddRoundKey,
// NR-1 full rounds, a final round without MixColumns, then a ciphertext handshake.
module aes_encrypt_round_ctrl #(
  parameter int NR      = 10,
  parameter int ROUND_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Key_Ready,
  input  logic               Out_Ready,
  output logic               Busy,
  output logic               Init_Load,
  output logic               State_En,
  output logic               MixCol_En,
  output logic [ROUND_W-1:0] Round_Idx,
  output logic               Out_Valid,
  output logic [CNT_W-1:0]   Block_Cnt
);

  // state  | meaning
  // IDLE   | waiting for Start with round keys ready
  // LOAD   | state reg <= plaintext ^ round key 0
  // ROUND  | rounds 1..NR-1, MixColumns enabled
  // FINAL  | round NR, MixColumns bypassed
  // OUTPUT | ciphertext valid until the consumer takes it
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUTPUT} state_t;

  localparam logic [ROUND_W-1:0] NR_IDX   = ROUND_W'(NR);
  localparam logic [ROUND_W-1:0] LAST_MIX = ROUND_W'(NR - 1);

  state_t             state, state_nxt;
  logic [ROUND_W-1:0] round_cnt, round_cnt_nxt;
  logic [CNT_W-1:0]   block_cnt_nxt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      Block_Cnt <= '0;
    end else begin
      state     <= state_nxt;
      round_cnt <= round_cnt_nxt;
      Block_Cnt <= block_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    round_cnt_nxt = round_cnt;
    block_cnt_nxt = Block_Cnt;
    Busy          = 1'b1;
    Init_Load     = 1'b0;
    State_En      = 1'b0;
    MixCol_En     = 1'b0;
    Round_Idx     = '0;
    Out_Valid     = 1'b0;

    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start && Key_Ready) state_nxt = LOAD;
      end
      LOAD: begin
        Init_Load     = 1'b1;
        round_cnt_nxt = ROUND_W'(1);
        state_nxt     = ROUND;
      end
      ROUND: begin
        State_En  = 1'b1;
        MixCol_En = 1'b1;
        Round_Idx = round_cnt;
        if (round_cnt == LAST_MIX) begin
          round_cnt_nxt = NR_IDX;
          state_nxt     = FINAL;
        end else begin
          round_cnt_nxt = round_cnt + ROUND_W'(1);
        end
      end
      FINAL: begin
        State_En  = 1'b1;
        Round_Idx = NR_IDX;
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        Out_Valid = 1'b1;
        Round_Idx = NR_IDX;
        if (Out_Ready) begin
          round_cnt_nxt = '0;
          block_cnt_nxt = Block_Cnt + CNT_W'(1);
          state_nxt     = IDLE;
        end
      end
      default: begin
        // unreachable encodings recover to an idle, zero-output state
        Busy          = 1'b0;
        round_cnt_nxt = '0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule
